uart_rx: RTL and testbench

// - UART receiver; the receive end of the uart_tx link. Deserialises one frame per start bit:

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for uart_rx / uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_HI
  } rx_state_t;

  localparam int unsigned LEN_MIN = 5;
  localparam int unsigned LEN_MAX = 8;

  function automatic logic calc_parity(input logic [LEN_MAX-1:0] data,
                                       input logic [3:0]         len,
                                       input logic               ptype);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < LEN_MAX; i++) begin
      if (i < 32'(len)) p = p ^ data[i];
    end
    return ptype ? p : ~p;
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (32'(len) < LEN_MIN) return 4'(LEN_MIN);
    if (32'(len) > LEN_MAX) return 4'(LEN_MAX);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Reset-to-value flop chain used to bring the asynchronous rx line into tx_clk.
module uart_rx_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic tx_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, one bit per tx_clk cycle. Define UART_RX_SYNC_EN to put a
// SYNC_STG-deep synchroniser in front of the FSM.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [3:0]        length,
  input  logic              parity_type,
  input  logic              parity_en,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_err
);

  localparam int unsigned LEN_TOP   = (DATA_W < LEN_MAX) ? DATA_W : LEN_MAX;
  localparam logic [3:0]  LEN_TOP_L = 4'(LEN_TOP);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync #(
    .STAGES  (SYNC_STG),
    .RST_VAL (1'b1)
  ) u_sync (
    .tx_clk (tx_clk),
    .rst    (rst),
    .d      (rx),
    .q      (rx_s)
  );
`else
  if (SYNC_STG == 0) begin : g_no_sync
  end
  assign rx_s = rx;
`endif

  rx_state_t         state, state_nxt;
  logic [3:0]        count;
  logic [3:0]        cfg_len;
  logic              cfg_ptype, cfg_pen, cfg_stop2;
  logic [DATA_W-1:0] shift_reg;
  logic              par_flag, frm_flag;

  logic              start, take_bit, chk_par, chk_stop, frame_end;
  logic              frm_now;
  logic [LEN_MAX-1:0] par_data;
  logic              par_exp;
  logic [3:0]        len_clamped;

  always_comb begin
    len_clamped = clamp_len(length);
    if (len_clamped > LEN_TOP_L) len_clamped = LEN_TOP_L;
  end

  always_comb begin
    par_data = '0;
    for (int unsigned i = 0; i < LEN_TOP; i++) par_data[i] = shift_reg[i];
    par_exp = calc_parity(par_data, cfg_len, cfg_ptype);
  end

  assign frm_now = frm_flag | (chk_stop & ~rx_s);

  always_ff @(posedge tx_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The frame-end edge must route on the flag including the stop bit sampled
  // at that same edge, hence frm_now rather than the registered frm_flag.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take_bit  = 1'b0;
    chk_par   = 1'b0;
    chk_stop  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start     = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        take_bit = 1'b1;
        if (count == cfg_len - 4'd1) state_nxt = cfg_pen ? PARITY : STOP1;
      end
      PARITY: begin
        chk_par   = 1'b1;
        state_nxt = STOP1;
      end
      STOP1: begin
        chk_stop = 1'b1;
        if (cfg_stop2) begin
          state_nxt = STOP2;
        end else begin
          frame_end = 1'b1;
          state_nxt = frm_now ? WAIT_HI : IDLE;
        end
      end
      STOP2: begin
        chk_stop  = 1'b1;
        frame_end = 1'b1;
        state_nxt = frm_now ? WAIT_HI : IDLE;
      end
      WAIT_HI: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      count         <= '0;
      cfg_len       <= 4'(LEN_MIN);
      cfg_ptype     <= 1'b0;
      cfg_pen       <= 1'b0;
      cfg_stop2     <= 1'b0;
      shift_reg     <= '0;
      par_flag      <= 1'b0;
      frm_flag      <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      rx_done <= frame_end;
      if (start) begin
        count     <= '0;
        shift_reg <= '0;
        cfg_len   <= len_clamped;
        cfg_ptype <= parity_type;
        cfg_pen   <= parity_en;
        cfg_stop2 <= stop2;
        par_flag  <= 1'b0;
        frm_flag  <= 1'b0;
      end
      if (take_bit) begin
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (32'(count) == i) shift_reg[i] <= rx_s;
        end
        count <= count + 4'd1;
      end
      if (chk_par && (rx_s != par_exp)) par_flag <= 1'b1;
      if (chk_stop && !rx_s)            frm_flag <= 1'b1;
      if (frame_end) begin
        rx_data       <= shift_reg;
        rx_parity_err <= par_flag;
        rx_frame_err  <= frm_now;
        rx_err        <= par_flag | frm_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed table-driven bench for uart_rx (synchroniser disabled).
module tb_uart_rx;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] length;
  logic       parity_type, parity_en, stop2;
  logic [7:0] rx_data;
  logic       rx_done, rx_parity_err, rx_frame_err, rx_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tx_clk = ~tx_clk;

  uart_rx #(.DATA_W(8), .SYNC_STG(2)) dut (
    .tx_clk        (tx_clk),
    .rst           (rst),
    .rx            (rx),
    .length        (length),
    .parity_type   (parity_type),
    .parity_en     (parity_en),
    .stop2         (stop2),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_err        (rx_err)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] length;
    int         nbits;
    logic       pen, ptype, pbit, stop2, s1, s2, glitch;
    logic [7:0] exp_data;
    logic       exp_perr, exp_ferr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame; returns at the negedge where rx_done should be high.
  task automatic drive_frame(input vec_t v, output bit early);
    logic fb [0:15];
    int   n;
    early = 1'b0;
    fb[0] = 1'b0;
    for (int i = 0; i < v.nbits; i++) fb[1+i] = v.data[i];
    n = 1 + v.nbits;
    if (v.pen) begin fb[n] = v.pbit; n++; end
    fb[n] = v.s1; n++;
    if (v.stop2) begin fb[n] = v.s2; n++; end
    for (int i = 0; i < n; i++) begin
      @(negedge tx_clk);
      if (i > 0 && rx_done) early = 1'b1;
      if (i == 0) begin
        length      = v.length;
        parity_en   = v.pen;
        parity_type = v.ptype;
        stop2       = v.stop2;
      end else if (i == 1 && v.glitch) begin
        length      = 4'd5;
        parity_en   = ~v.pen;
        parity_type = ~v.ptype;
        stop2       = ~v.stop2;
      end
      rx = fb[i];
    end
    @(negedge tx_clk);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input bit early);
    check({tag, ".no_early_done"}, 32'(early), 32'd0);
    check({tag, ".done"},     32'(rx_done),       32'd1);
    check({tag, ".data"},     32'(rx_data),       32'(v.exp_data));
    check({tag, ".perr"},     32'(rx_parity_err), 32'(v.exp_perr));
    check({tag, ".ferr"},     32'(rx_frame_err),  32'(v.exp_ferr));
    check({tag, ".err"},      32'(rx_err),        32'(v.exp_perr | v.exp_ferr));
  endtask

  initial begin
    bit   early;
    vec_t v;
    int   done_cnt;
    logic fb2 [0:19];
    logic [7:0] fa, fbb;

    //          data   len    n  pen  pty  pbit st2  s1   s2   glt  exp    perr ferr
    vecs[0] = '{8'h55, 4'd8,  8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h55,1'b0,1'b0};
    vecs[1] = '{8'h16, 4'd5,  5, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,8'h16,1'b0,1'b0};
    vecs[2] = '{8'h16, 4'd5,  5, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,8'h16,1'b1,1'b0};
    vecs[3] = '{8'hA3, 4'd8,  8, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,8'hA3,1'b0,1'b1};
    vecs[4] = '{8'hF0, 4'd12, 8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'hF0,1'b0,1'b0};
    vecs[5] = '{8'h0D, 4'd3,  5, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h0D,1'b0,1'b0};
    vecs[6] = '{8'h2B, 4'd6,  6, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,8'h2B,1'b0,1'b0};
    vecs[7] = '{8'h5A, 4'd7,  7, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,1'b1,1'b1};
    vecs[8] = '{8'h96, 4'd8,  8, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,8'h96,1'b0,1'b0};
    vecs[9] = '{8'hC7, 4'd8,  8, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'hC7,1'b0,1'b1};

    rst = 1'b1; rx = 1'b1; length = 4'd8;
    parity_type = 1'b0; parity_en = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge tx_clk);
    check("reset.data", 32'(rx_data), 32'd0);
    check("reset.done", 32'(rx_done), 32'd0);
    check("reset.err",  32'({rx_parity_err, rx_frame_err, rx_err}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge tx_clk);

    for (int k = 0; k < 10; k++) begin
      drive_frame(vecs[k], early);
      check_frame($sformatf("vec%0d", k), vecs[k], early);
      rx = 1'b1;
      @(negedge tx_clk);
      check($sformatf("vec%0d.pulse_off", k), 32'(rx_done), 32'd0);
      check($sformatf("vec%0d.hold", k), 32'(rx_data), 32'(vecs[k].exp_data));
      @(negedge tx_clk);
    end

    // Held-low line after a frame error must not retrigger.
    drive_frame(vecs[3], early);
    check_frame("wait_hi.frame", vecs[3], early);
    rx = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge tx_clk);
      if (rx_done) done_cnt++;
    end
    check("wait_hi.no_retrigger", 32'(done_cnt), 32'd0);
    rx = 1'b1;
    @(negedge tx_clk);
    v = vecs[0]; v.data = 8'h81; v.exp_data = 8'h81;
    drive_frame(v, early);
    check_frame("wait_hi.rearm", v, early);
    rx = 1'b1;
    repeat (2) @(negedge tx_clk);

    // Back-to-back 8N1 frames, F = 10.
    fa = 8'h3C; fbb = 8'hC3;
    fb2[0] = 1'b0; fb2[9] = 1'b1; fb2[10] = 1'b0; fb2[19] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fb2[1+i]  = fa[i];
      fb2[11+i] = fbb[i];
    end
    length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    done_cnt = 0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge tx_clk);
      if (j > 0 && rx_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          check("b2b.first_at", 32'(j), 32'd10);
          check("b2b.first_data", 32'(rx_data), 32'h3C);
        end else if (done_cnt == 2) begin
          check("b2b.second_at", 32'(j), 32'd20);
          check("b2b.second_data", 32'(rx_data), 32'hC3);
        end
      end
      if (j < 20) rx = fb2[j];
      else        rx = 1'b1;
    end
    check("b2b.count", 32'(done_cnt), 32'd2);
    @(negedge tx_clk);

    // Reset while data bit 3 is on the line.
    fa = 8'hE5;
    @(negedge tx_clk); rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge tx_clk);
      rx = fa[i];
      if (i == 3) rst = 1'b1;
    end
    @(negedge tx_clk);
    check("midrst.data", 32'(rx_data), 32'd0);
    check("midrst.flags", 32'({rx_done, rx_parity_err, rx_frame_err, rx_err}), 32'd0);
    rst = 1'b0; rx = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge tx_clk);
      if (rx_done) done_cnt++;
    end
    check("midrst.no_done", 32'(done_cnt), 32'd0);
    v = vecs[0]; v.data = 8'h6E; v.exp_data = 8'h6E;
    drive_frame(v, early);
    check_frame("midrst.next", v, early);
    rx = 1'b1;
    repeat (2) @(negedge tx_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
